// File: rtl/shift_unit_iter.sv
// Iterative barrel shifter: one binary-weighted stage per clock, SHAMT_W stages per operation.
// Optional rotate-left for op 11 is enabled by defining SHIFT_UNIT_ROTATE_EN.
module shift_unit_iter #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   in,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [1:0]         op,
    output logic               ready,
    output logic               done,
    output logic [WIDTH-1:0]   out
);

    localparam int K_W = (SHAMT_W > 1) ? $clog2(SHAMT_W) : 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(SHAMT_W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [K_W-1:0]     k_q, k_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [SHAMT_W-1:0] shamt_q, shamt_d;
    logic [1:0]         op_q, op_d;
    logic               sign_q, sign_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic               done_q, done_d;

    logic               is_right;
    logic               fill_bit;
    logic               stage_bit;
    logic [WIDTH-1:0]   stage_sel;
    logic [WIDTH-1:0]   stage_res [SHAMT_W];

    // srl and sra share the right-shift path; only the fill bit differs.
    assign is_right = (op_q == 2'b01) || (op_q == 2'b10);
    assign fill_bit = (op_q == 2'b10) && sign_q;

`ifdef SHIFT_UNIT_ROTATE_EN
    logic is_rot;
    assign is_rot = (op_q == 2'b11);
`endif

    genvar gi;
    generate
        for (gi = 0; gi < SHAMT_W; gi++) begin : g_stage
            localparam int S = 1 << gi;
            logic [WIDTH-1:0] left_s;
            logic [WIDTH-1:0] right_s;

            assign left_s  = {work_q[WIDTH-1-S:0], {S{1'b0}}};
            assign right_s = {{S{fill_bit}}, work_q[WIDTH-1:S]};

`ifdef SHIFT_UNIT_ROTATE_EN
            logic [WIDTH-1:0] rot_s;
            assign rot_s = {work_q[WIDTH-1-S:0], work_q[WIDTH-1:WIDTH-S]};
            assign stage_res[gi] = is_rot ? rot_s : (is_right ? right_s : left_s);
`else
            assign stage_res[gi] = is_right ? right_s : left_s;
`endif
        end
    endgenerate

    // Pick the candidate for the current stage and whether its shamt bit is set.
    always_comb begin
        stage_bit = 1'b0;
        stage_sel = work_q;
        for (int i = 0; i < SHAMT_W; i++) begin
            if (k_q == K_W'(i)) begin
                stage_bit = shamt_q[i];
                stage_sel = stage_res[i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        work_d  = work_q;
        shamt_d = shamt_q;
        op_d    = op_q;
        sign_d  = sign_q;
        out_d   = out_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    work_d  = in;
                    shamt_d = shamt;
                    op_d    = op;
                    sign_d  = in[WIDTH-1];
                    k_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (stage_bit) begin
                    work_d = stage_sel;
                end
                k_d = k_q + 1'b1;
                if (k_q == K_LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // done and out are registered so they appear together on the edge leaving DONE.
                out_d   = work_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            k_q     <= '0;
            work_q  <= '0;
            shamt_q <= '0;
            op_q    <= '0;
            sign_q  <= 1'b0;
            out_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            work_q  <= work_d;
            shamt_q <= shamt_d;
            op_q    <= op_d;
            sign_q  <= sign_d;
            out_q   <= out_d;
            done_q  <= done_d;
        end
    end

    assign ready = (state_q == IDLE);
    assign done  = done_q;
    assign out   = out_q;

endmodule

// File: doc/shift_unit_iter.md
SHIFT_UNIT_ITER -- requirements
Module: shift_unit_iter

Interface
REQ-001 The block SHALL have a parameter WIDTH, default 32, giving the operand and result width in bits; it shall be a power of two of at least 4.
REQ-002 The block SHALL have a parameter SHAMT_W, default 5, giving the shift-amount width; it shall equal log2(WIDTH).
REQ-003 The block SHALL have the port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have the port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have the port start, input, 1 bit: request to begin a shift operation.
REQ-006 The block SHALL have the port in, input, WIDTH bits: the operand.
REQ-007 The block SHALL have the port shamt, input, SHAMT_W bits: the unsigned shift amount.
REQ-008 The block SHALL have the port op, input, 2 bits: 00 sll, 01 srl, 10 sra, 11 rol (see Configuration).
REQ-009 The block SHALL have the port ready, output, 1 bit: high when start will be accepted.
REQ-010 The block SHALL have the port done, output, 1 bit: a one-cycle pulse marking a valid result.
REQ-011 The block SHALL have the port out, output, WIDTH bits: the result register.

Function
REQ-012 The block SHALL implement an FSM with three states: IDLE, RUN and DONE.
REQ-013 In IDLE, ready SHALL be 1; in RUN and DONE, ready SHALL be 0.
REQ-014 A start sampled high in IDLE SHALL latch in, shamt and op into internal registers, clear the stage counter and move the FSM to RUN.
REQ-015 A start sampled while in RUN or DONE SHALL be ignored with no effect on the operation in flight.
REQ-016 Each RUN cycle with stage counter k SHALL shift the working register by 2^k when bit k of the latched shamt is 1, or hold it when that bit is 0, then increment k.
REQ-017 When k = SHAMT_W-1 has been processed, the FSM SHALL move to DONE.
REQ-018 sll SHALL zero-fill from the LSB; srl SHALL zero-fill from the MSB; sra SHALL replicate the latched operand MSB.
REQ-019 The DONE state SHALL last exactly one cycle, assert done and load out with the working register; the next state SHALL be IDLE.
REQ-020 Latency: if start is accepted at edge N, done SHALL be high from edge N+SHAMT_W+1 to edge N+SHAMT_W+2, independent of the shamt value, including shamt = 0.
REQ-021 out SHALL hold its value from DONE until the next DONE.
REQ-022 out SHALL NOT change while RUN is in progress.
REQ-023 Back-to-back operation: a start accepted in the IDLE cycle immediately after DONE SHALL be serviced, giving a throughput of one operation per SHAMT_W+2 cycles.
REQ-024 The block SHALL NOT truncate or wrap shamt; the maximum shift is WIDTH-1.

Reset
REQ-025 When reset is high at a rising edge, the block SHALL force the FSM to IDLE, out to 0, done to 0, ready to 1, and the stage counter and latched registers to 0.
REQ-026 Reset SHALL take priority over start in the same cycle.
REQ-027 A reset during RUN SHALL abort the operation with no done pulse; the next start after reset deasserts SHALL be accepted normally.

Configuration
REQ-028 With macro SHIFT_UNIT_ROTATE_EN defined, op 11 SHALL perform rotate-left: bits leaving the MSB re-enter at the LSB in each stage.
REQ-029 Without SHIFT_UNIT_ROTATE_EN, op 11 SHALL behave exactly as sll, and no rotate logic SHALL be present.

Verification
REQ-030 Directed sll case: WIDTH=32, op=00, in=0x0000FFFF, shamt=16, start in IDLE -> done exactly 6 cycles after the accept edge, out=0xFFFF0000.
REQ-031 Directed srl/sra case: in=0x80000000, shamt=4 -> op=01 gives out=0x08000000; op=10 gives out=0xF8000000.
REQ-032 Directed zero-shift case: in=0x12345678, shamt=0, op=00 -> out=0x12345678 with the full 6-cycle latency; ready low throughout.
REQ-033 Directed collision case: start pulsed again with in=0xFFFFFFFF two cycles into RUN -> ignored; first result is unaffected and exactly one done pulse occurs.
REQ-034 Directed reset case: reset asserted during RUN stage 2 -> no done pulse, out=0 and ready=1 on the next cycle; a subsequent sll of 1 by 31 gives 0x80000000.
REQ-035 Directed rotate case: with SHIFT_UNIT_ROTATE_EN defined, in=0x80000001, op=11, shamt=1 -> out=0x00000003; without the macro, the same stimulus -> out=0x00000002.
